// File: rtl/convert_sequencer_if.sv
// Bus bundle for convert_sequencer: sample input, converter
// side, packed output stream and the sticky status flags.
interface convert_sequencer_if;
    logic                 CLR;
    logic                 WR_EN;
    logic [31:0]          WR_DATA;
    logic                 IN_READY;
    logic [7:0][31:0]     CVRT_DIN;
    logic                 CVRT;
    logic                 CVRT_END;
    logic [3:0][63:0]     CVRT_DOUT;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [63:0]          OUT_DATA;
    logic                 OUT_LAST;
    logic                 OVF;
    logic                 TMO;

    modport slave (
        input  CLR, WR_EN, WR_DATA, CVRT_END, CVRT_DOUT, OUT_READY,
        output IN_READY, CVRT_DIN, CVRT, OUT_VALID, OUT_DATA,
        output OUT_LAST, OVF, TMO
    );

    modport master (
        output CLR, WR_EN, WR_DATA, CVRT_END, CVRT_DOUT, OUT_READY,
        input  IN_READY, CVRT_DIN, CVRT, OUT_VALID, OUT_DATA,
        input  OUT_LAST, OVF, TMO
    );
endinterface

// File: rtl/convert_sequencer.sv
// Front-end for the 32-to-64 converter: gathers 8 words, fires a
// convert, waits with a timeout, then drains 4 packed beats.
module convert_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    convert_sequencer_if.slave bus
);
    typedef enum logic [1:0] {FILL, CONV, WAIT, DRAIN} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       idx;
    logic [1:0]       beat;
    logic [7:0]       wait_cnt;
    logic [7:0][31:0] din;
    logic [3:0][63:0] cap;
    logic [63:0]      out_data;
    logic             ovf;
    logic             tmo;
    logic             wr_acc;
    logic             wr_drop;
    logic             out_hs;
    logic             cvt_done;
    logic             cvt_tmo;

    assign wr_acc   = (state == FILL) && bus.WR_EN;
    assign wr_drop  = (state != FILL) && bus.WR_EN;
    assign out_hs   = (state == DRAIN) && bus.OUT_READY;
    assign cvt_done = (state == WAIT) && bus.CVRT_END;
    assign cvt_tmo  = (state == WAIT) && !bus.CVRT_END
                      && (wait_cnt == WAIT_LAST);

    // next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (wr_acc && idx == 3'd7) state_nxt = CONV;
            CONV:    state_nxt = WAIT;
            WAIT: begin
                if (cvt_done)     state_nxt = DRAIN;
                else if (cvt_tmo) state_nxt = FILL;
            end
            DRAIN:   if (out_hs && beat == 2'd3) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // state register
    always_ff @(posedge CLK) begin
        if (!nRST) state <= FILL;
        else       state <= state_nxt;
    end

    // frame buffer, wait counter, result capture and beat select
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            idx      <= '0;
            beat     <= '0;
            wait_cnt <= '0;
            din      <= '0;
            cap      <= '0;
            out_data <= '0;
        end else begin
            if (wr_acc) begin
                din[idx] <= bus.WR_DATA;
                idx      <= idx + 3'd1;
            end
            if (state == CONV)
                wait_cnt <= '0;
            else if (state == WAIT && !bus.CVRT_END)
                wait_cnt <= wait_cnt + 8'd1;
            if (cvt_done) begin
                cap      <= bus.CVRT_DOUT;
                out_data <= bus.CVRT_DOUT[3];
                beat     <= '0;
            end else if (out_hs) begin
                beat     <= beat + 2'd1;
                out_data <= cap[2'd2 - beat];
            end
        end
    end

    // sticky flags; a set in the same cycle as CLR wins
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ovf <= 1'b0;
            tmo <= 1'b0;
        end else begin
            if (wr_drop)      ovf <= 1'b1;
            else if (bus.CLR) ovf <= 1'b0;
            if (cvt_tmo)      tmo <= 1'b1;
            else if (bus.CLR) tmo <= 1'b0;
        end
    end

    assign bus.IN_READY  = (state == FILL);
    assign bus.CVRT      = (state == CONV);
    assign bus.OUT_VALID = (state == DRAIN);
    assign bus.OUT_LAST  = (state == DRAIN) && (beat == 2'd3);
    assign bus.OUT_DATA  = out_data;
    assign bus.CVRT_DIN  = din;
    assign bus.OVF       = ovf;
    assign bus.TMO       = tmo;
endmodule

// File: doc/convert_sequencer.md
# convert_sequencer

Front-end controller for the 32-to-64-bit data converter in the sample path. Collects eight 32-bit sample words over a valid/ready-style input and presents them as the converter's 8-word input array. It then pulses the convert request, waits for convert-done with a timeout, and streams the four packed 64-bit results downstream with a valid/ready handshake. It sits between the sample FIFO and the packetiser; the converter's own input and output registers are driven and consumed only through this block.

## Interface
- TIMEOUT, 16: max cycles spent waiting for CVRT_END after CVRT before aborting; legal range 2..255.

- CLK  in  1  clock; all logic on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- CLR  in  1  clears sticky flags OVF and TMO; no effect on the FSM.
- WR_EN  in  1  input word strobe.
- WR_DATA  in  32  input sample word.
- IN_READY  out  1  high when a WR_EN word will be accepted this cycle.
- CVRT_DIN  out  32 x 8  converter input array; element i = i-th accepted word of the frame.
- CVRT  out  1  one-cycle convert request to converter.
- CVRT_END  in  1  converter done; DOUT valid in the same cycle.
- CVRT_DOUT  in  64 x 4  converter output array.
- OUT_VALID  out  1  OUT_DATA holds a valid beat.
- OUT_READY  in  1  downstream accepts beat when OUT_VALID and OUT_READY are both high.
- OUT_DATA  out  64  output beat.
- OUT_LAST  out  1  high with beat 3 of a frame.
- OVF  out  1  sticky: WR_EN seen while IN_READY=0 (word dropped).
- TMO  out  1  sticky: converter timeout occurred.

## Operation
- FSM states: FILL, CONV, WAIT, DRAIN.
- FILL:
  - IN_READY=1.
  - On WR_EN, write WR_DATA into CVRT_DIN[idx] and increment idx (3 bits).
  - When the word with idx=7 is accepted: idx wraps to 0 and the FSM goes to CONV.
- CONV:
  - CVRT=1 for exactly this one cycle.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - If CVRT_END=1: capture CVRT_DOUT[3..0] into 4 output registers, clear the beat index, go to DRAIN.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT with no CVRT_END: set TMO, discard the frame, go to FILL.
- DRAIN:
  - OUT_VALID=1.
  - Beat index b selects the output: OUT_DATA = captured CVRT_DOUT[3-b], so beat 0 = {word0, word1} and beat 3 = {word6, word7}.
  - OUT_LAST = (b==3).
  - b advances only on handshake; OUT_DATA and OUT_LAST are held stable while OUT_READY=0.
  - After the beat-3 handshake, go to FILL.
- CVRT_END outside WAIT is ignored and not flagged.
- CVRT_DIN holds its contents outside FILL; the converter is guaranteed stable input from CONV through its capture.
- OVF: set by WR_EN while IN_READY=0 (states CONV, WAIT, DRAIN); that word is dropped and idx is unchanged.
- CLR: clears OVF and TMO. If CLR and a set condition occur in the same cycle, the set wins.

## Timing
- Reset values:
  - State FILL, idx=0, b=0, wait counter 0.
  - IN_READY=1, CVRT=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, CVRT_DIN all 0, OVF=0, TMO=0.
- Reset mid-frame (any state) abandons the frame; no partial beats are emitted afterwards.
- Outputs are registered or decoded from state only; there is no combinational path from OUT_READY or WR_EN to any output.
- With the standard converter (CVRT_END one cycle after CVRT):
  - Last input word accepted at cycle t.
  - CVRT high in cycle t+1.
  - CVRT_END sampled in cycle t+2.
  - First OUT_VALID in cycle t+3.
  - With OUT_READY held high, beats 0..3 occupy cycles t+3..t+6.
  - IN_READY returns in cycle t+7.
- Frame throughput with no backpressure: 8 fill + 1 CONV + 1 WAIT + 4 DRAIN = 14 cycles.
- Timeout boundary: CVRT_END in the WAIT cycle where the counter equals TIMEOUT-1 is still accepted. TMO is set in the following cycle if CVRT_END is absent.

## Test plan
- Reset, then WR_EN with words 0x00..0x07 back-to-back, OUT_READY=1:
  - Exactly one CVRT pulse.
  - Beats {0x00,0x01}, {0x02,0x03}, {0x04,0x05}, {0x06,0x07} on consecutive cycles.
  - OUT_LAST only on the 4th beat; OVF=0, TMO=0.
- Same frame with OUT_READY toggling 1,0,0,1,0,1,1:
  - Each beat is held stable while stalled; exactly 4 handshakes; no beat duplicated or lost.
- WR_EN held high continuously across a frame with 9 words:
  - 9th word dropped; OVF=1; the next frame starts with the 10th word at CVRT_DIN[0].
  - CLR pulse then returns OVF to 0.
- CVRT_END tied low, TIMEOUT=16:
  - TMO rises 16 cycles after CVRT; no OUT_VALID; IN_READY returns.
  - A following good frame drains correctly.
- nRST asserted for 1 cycle during DRAIN after beat 1:
  - All outputs return to reset values next cycle; no further beats.
  - A fresh 8-word frame converts normally.
- CVRT_END injected during FILL and DRAIN:
  - Ignored; no capture; no state change; no flag set.
